regfile_wr_arbiter: RTL and testbench

- Shares the register file's single write port between the in-order pipeline writeback (MEM/WB) and the long-latency multiply/divide unit (MDU).
- MDU results are queued in a small FIFO.
- The pipeline has priority, with an anti-starvation limit and a WAW-ordering guard.
- Sits between MEM/WB and the register file write port. It also provides busy flags so ID can stall on registers with pending MDU results.

---
 rtl/regfile_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter: shares the register file write port between MEM/WB and a
// queued MDU result FIFO. Optional statistics via WRARB_STATS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_wr_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int AW           = 5,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pl_we,
  input  logic [AW-1:0] pl_addr,
  input  logic [DW-1:0] pl_data,
  output logic          pl_stall,
  input  logic          mdu_valid,
  input  logic [AW-1:0] mdu_addr,
  input  logic [DW-1:0] mdu_data,
  output logic          mdu_ready,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          rd_busy1,
  output logic          rd_busy2,
  output logic          wb_we,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data
`ifdef WRARB_STATS_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   forced_grants
`else
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [PW:0]   FULL_CNT   = (PW+1)'(DEPTH);

  logic [AW-1:0]    fifo_addr [DEPTH];
  logic [DW-1:0]    fifo_data [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic [SW-1:0]    starve_cnt;
  logic [DEPTH-1:0] entry_valid;
  logic             fifo_hit;
  logic             hit1;
  logic             hit2;
  logic             empty;
  logic             full;
  logic             pl_req;
  logic             starved;
  logic             gnt_fifo;
  logic             gnt_pl;
  logic             push;
  logic             pop;

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    entry_valid = '0;
    fifo_hit    = 1'b0;
    hit1        = 1'b0;
    hit2        = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, PW'(i) - rd_ptr} < count);
      if (entry_valid[i] && fifo_addr[i] == pl_addr)  fifo_hit = 1'b1;
      if (entry_valid[i] && fifo_addr[i] == rd_addr1) hit1     = 1'b1;
      if (entry_valid[i] && fifo_addr[i] == rd_addr2) hit2     = 1'b1;
    end
  end

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pl_req   = pl_we && (pl_addr != '0);
  assign starved  = (starve_cnt == STARVE_MAX);
  assign gnt_fifo = !empty && (!pl_req || starved || fifo_hit);
  assign gnt_pl   = pl_req && !gnt_fifo;
  assign pop      = gnt_fifo;
  assign push     = mdu_valid && mdu_ready;

  assign pl_stall  = !rst && pl_req && gnt_fifo;
  assign mdu_ready = !rst && !full;
  assign rd_busy1  = !rst && (rd_addr1 != '0) && hit1;
  assign rd_busy2  = !rst && (rd_addr2 != '0) && hit2;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mdu_addr;
      fifo_data[wr_ptr] <= mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      wb_we      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (pop || empty)                 starve_cnt <= '0;
      else if (gnt_pl && !starved)      starve_cnt <= starve_cnt + 1'b1;

      // r0-destined MDU results still pop, but never assert the write enable.
      if (gnt_fifo) begin
        wb_we   <= (fifo_addr[rd_ptr] != '0);
        wb_addr <= fifo_addr[rd_ptr];
        wb_data <= fifo_data[rd_ptr];
      end else if (gnt_pl) begin
        wb_we   <= 1'b1;
        wb_addr <= pl_addr;
        wb_data <= pl_data;
      end else begin
        wb_we   <= 1'b0;
      end
    end
  end

`ifdef WRARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles  <= '0;
      forced_grants <= '0;
    end else begin
      if (pl_stall) stall_cycles <= stall_cycles + 32'd1;
      if (gnt_fifo && pl_req && starved && !fifo_hit) forced_grants <= forced_grants + 32'd1;
    end
  end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter (default parameters).
`default_nettype none

module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pl_we;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;
  logic        pl_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        rd_busy1;
  logic        rd_busy2;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
`ifdef WRARB_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] forced_grants;
`endif

  int errors = 0;
  int checks = 0;

  regfile_wr_arbiter dut (
    .clk(clk), .rst(rst),
    .pl_we(pl_we), .pl_addr(pl_addr), .pl_data(pl_data), .pl_stall(pl_stall),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
`ifdef WRARB_STATS_EN
    , .stall_cycles(stall_cycles), .forced_grants(forced_grants)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; pl_we = 1'b1; pl_addr = 5'd5; pl_data = 32'h1;
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h7; rd_addr1 = 5'd7; rd_addr2 = 5'd7;
    tick; tick;
    checks++;
    if ({pl_stall, mdu_ready, rd_busy1, rd_busy2} !== 4'b0000) begin
      errors++; $display("FAIL reset_comb: got %b expected 0000", {pl_stall, mdu_ready, rd_busy1, rd_busy2});
    end
    checks++;
    if ({wb_we, wb_addr, wb_data} !== 38'd0) begin
      errors++; $display("FAIL reset_wb: got %h expected 0", {wb_we, wb_addr, wb_data});
    end
    pl_we = 1'b0; mdu_valid = 1'b0; rst = 1'b0;
    #1;
    checks++;
    if ({pl_stall, mdu_ready, rd_busy1} !== 3'b010) begin
      errors++; $display("FAIL post_reset_comb: got %b expected 010", {pl_stall, mdu_ready, rd_busy1});
    end
    tick;
    checks++;
    if (wb_we !== 1'b0) begin
      errors++; $display("FAIL post_reset_we: got %b expected 0", wb_we);
    end
  endtask

  task automatic test_pipeline;
    pl_we = 1'b1; pl_addr = 5'd5; pl_data = 32'hA5;
    #1;
    checks++;
    if (pl_stall !== 1'b0) begin
      errors++; $display("FAIL pl_stall_idle: got %b expected 0", pl_stall);
    end
    tick;
    checks++;
    if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd5, 32'hA5}) begin
      errors++; $display("FAIL pl_write: got %h expected %h", {wb_we, wb_addr, wb_data}, {1'b1, 5'd5, 32'hA5});
    end
    pl_we = 1'b0;
    tick;
    checks++;
    if ({wb_we, wb_addr, wb_data} !== {1'b0, 5'd5, 32'hA5}) begin
      errors++; $display("FAIL idle_hold: got %h expected %h", {wb_we, wb_addr, wb_data}, {1'b0, 5'd5, 32'hA5});
    end
  endtask

  task automatic test_mdu_latency;
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h1234; rd_addr1 = 5'd7;
    #1;
    checks++;
    if ({mdu_ready, rd_busy1} !== 2'b10) begin
      errors++; $display("FAIL mdu_accept: got %b expected 10", {mdu_ready, rd_busy1});
    end
    tick;
    mdu_valid = 1'b0;
    #1;
    checks++;
    if ({rd_busy1, wb_we} !== 2'b10) begin
      errors++; $display("FAIL mdu_busy_nobypass: got %b expected 10", {rd_busy1, wb_we});
    end
    tick;
    checks++;
    if ({wb_we, wb_addr, wb_data, rd_busy1} !== {1'b1, 5'd7, 32'h1234, 1'b0}) begin
      errors++; $display("FAIL mdu_write: got %h expected %h", {wb_we, wb_addr, wb_data, rd_busy1}, {1'b1, 5'd7, 32'h1234, 1'b0});
    end
  endtask

  task automatic test_back_to_back;
    mdu_valid = 1'b1; mdu_addr = 5'd6; mdu_data = 32'h66;
    tick;
    mdu_addr = 5'd8; mdu_data = 32'h88; rd_addr1 = 5'd8; rd_addr2 = 5'd6;
    #1;
    checks++;
    if ({mdu_ready, rd_busy1, rd_busy2} !== 3'b101) begin
      errors++; $display("FAIL b2b_flags: got %b expected 101", {mdu_ready, rd_busy1, rd_busy2});
    end
    tick;
    mdu_valid = 1'b0;
    #1;
    checks++;
    if ({wb_we, wb_addr, wb_data, rd_busy1, rd_busy2} !== {1'b1, 5'd6, 32'h66, 2'b10}) begin
      errors++; $display("FAIL b2b_first: got %h expected %h", {wb_we, wb_addr, wb_data, rd_busy1, rd_busy2}, {1'b1, 5'd6, 32'h66, 2'b10});
    end
    tick;
    checks++;
    if ({wb_we, wb_addr, wb_data, rd_busy1} !== {1'b1, 5'd8, 32'h88, 1'b0}) begin
      errors++; $display("FAIL b2b_second: got %h expected %h", {wb_we, wb_addr, wb_data, rd_busy1}, {1'b1, 5'd8, 32'h88, 1'b0});
    end
  endtask

  task automatic test_starvation;
    mdu_valid = 1'b1; mdu_addr = 5'd3; mdu_data = 32'h33;
    tick;
    mdu_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pl_we = 1'b1; pl_addr = 5'(9 + k); pl_data = 32'(8'h90 + k);
      #1;
      checks++;
      if (pl_stall !== 1'b0) begin
        errors++; $display("FAIL starve_pl_stall%0d: got %b expected 0", k, pl_stall);
      end
      tick;
      checks++;
      if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'(9 + k), 32'(8'h90 + k)}) begin
        errors++; $display("FAIL starve_pl_write%0d: got %h expected %h", k, {wb_we, wb_addr, wb_data}, {1'b1, 5'(9 + k), 32'(8'h90 + k)});
      end
    end
    pl_addr = 5'd12; pl_data = 32'h9C;
    #1;
    checks++;
    if (pl_stall !== 1'b1) begin
      errors++; $display("FAIL starve_forced_stall: got %b expected 1", pl_stall);
    end
    tick;
    checks++;
    if ({wb_we, wb_addr, wb_data, pl_stall} !== {1'b1, 5'd3, 32'h33, 1'b0}) begin
      errors++; $display("FAIL starve_fifo_write: got %h expected %h", {wb_we, wb_addr, wb_data, pl_stall}, {1'b1, 5'd3, 32'h33, 1'b0});
    end
    tick;
    pl_we = 1'b0;
    checks++;
    if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd12, 32'h9C}) begin
      errors++; $display("FAIL starve_retry_write: got %h expected %h", {wb_we, wb_addr, wb_data}, {1'b1, 5'd12, 32'h9C});
    end
  endtask

  task automatic test_waw;
    mdu_valid = 1'b1; mdu_addr = 5'd4; mdu_data = 32'h11;
    tick;
    mdu_valid = 1'b0; pl_we = 1'b1; pl_addr = 5'd4; pl_data = 32'h22;
    #1;
    checks++;
    if (pl_stall !== 1'b1) begin
      errors++; $display("FAIL waw_stall: got %b expected 1", pl_stall);
    end
    tick;
    checks++;
    if ({wb_we, wb_addr, wb_data, pl_stall} !== {1'b1, 5'd4, 32'h11, 1'b0}) begin
      errors++; $display("FAIL waw_mdu_first: got %h expected %h", {wb_we, wb_addr, wb_data, pl_stall}, {1'b1, 5'd4, 32'h11, 1'b0});
    end
    tick;
    pl_we = 1'b0;
    checks++;
    if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd4, 32'h22}) begin
      errors++; $display("FAIL waw_pl_second: got %h expected %h", {wb_we, wb_addr, wb_data}, {1'b1, 5'd4, 32'h22});
    end
  endtask

  task automatic test_full;
    for (int c = 0; c < 4; c++) begin
      pl_we = 1'b1; pl_addr = 5'd20; pl_data = 32'h200 + 32'(c);
      mdu_valid = 1'b1; mdu_addr = 5'(21 + c); mdu_data = 32'h101 + 32'(c);
      #1;
      checks++;
      if ({pl_stall, mdu_ready} !== 2'b01) begin
        errors++; $display("FAIL full_fill_flags%0d: got %b expected 01", c, {pl_stall, mdu_ready});
      end
      tick;
      checks++;
      if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd20, 32'h200 + 32'(c)}) begin
        errors++; $display("FAIL full_pl_write%0d: got %h expected %h", c, {wb_we, wb_addr, wb_data}, {1'b1, 5'd20, 32'h200 + 32'(c)});
      end
    end
    pl_data = 32'h204; mdu_addr = 5'd25; mdu_data = 32'h105;
    #1;
    checks++;
    if ({pl_stall, mdu_ready} !== 2'b10) begin
      errors++; $display("FAIL full_not_ready: got %b expected 10", {pl_stall, mdu_ready});
    end
    tick;
    checks++;
    if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd21, 32'h101}) begin
      errors++; $display("FAIL full_forced_pop: got %h expected %h", {wb_we, wb_addr, wb_data}, {1'b1, 5'd21, 32'h101});
    end
    #1;
    checks++;
    if ({pl_stall, mdu_ready} !== 2'b01) begin
      errors++; $display("FAIL full_reopen: got %b expected 01", {pl_stall, mdu_ready});
    end
    tick;
    checks++;
    if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd20, 32'h204}) begin
      errors++; $display("FAIL full_pl_retry: got %h expected %h", {wb_we, wb_addr, wb_data}, {1'b1, 5'd20, 32'h204});
    end
    pl_we = 1'b0; mdu_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++;
      if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'(22 + k), 32'h102 + 32'(k)}) begin
        errors++; $display("FAIL full_drain%0d: got %h expected %h", k, {wb_we, wb_addr, wb_data}, {1'b1, 5'(22 + k), 32'h102 + 32'(k)});
      end
    end
    tick;
    checks++;
    if (wb_we !== 1'b0) begin
      errors++; $display("FAIL full_drained: got %b expected 0", wb_we);
    end
  endtask

  task automatic test_r0;
    pl_we = 1'b1; pl_addr = 5'd0; pl_data = 32'hDEAD;
    #1;
    checks++;
    if (pl_stall !== 1'b0) begin
      errors++; $display("FAIL r0_pl_stall: got %b expected 0", pl_stall);
    end
    tick;
    checks++;
    if (wb_we !== 1'b0) begin
      errors++; $display("FAIL r0_pl_dropped: got %b expected 0", wb_we);
    end
    pl_we = 1'b0; mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'h55; rd_addr1 = 5'd0;
    tick;
    mdu_valid = 1'b0; pl_we = 1'b1;
    #1;
    checks++;
    if ({pl_stall, rd_busy1, wb_we} !== 3'b000) begin
      errors++; $display("FAIL r0_queued_flags: got %b expected 000", {pl_stall, rd_busy1, wb_we});
    end
    tick;
    pl_we = 1'b0;
    checks++;
    if ({wb_we, wb_addr, wb_data} !== {1'b0, 5'd0, 32'h55}) begin
      errors++; $display("FAIL r0_mdu_pop: got %h expected %h", {wb_we, wb_addr, wb_data}, {1'b0, 5'd0, 32'h55});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0; rd_addr1 = '0; rd_addr2 = '0;
    test_reset;
    test_pipeline;
    test_mdu_latency;
    test_back_to_back;
    test_starvation;
    test_waw;
    test_full;
    test_r0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
